// File: rtl/voice_allocator.sv
// voice_allocator: polyphony scheduler for a bank of midi_player voices.
//
// Events (note-on/note-off) are accepted one at a time. Each note-on is given
// to a voice already holding that note (retrigger), to the lowest-index free
// voice, or, when every voice is busy, to the oldest voice (steal). Retriggered
// and stolen voices hold their gate low for RETRIG_CYCLES cycles so the
// downstream ADSR restarts.
//
// Optional feature macro: VOICE_ALLOC_STEAL_EN
//   defined   - a note-on with every voice busy steals the oldest voice
//   undefined - such a note-on is discarded and drop_pulse fires instead
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ev_valid       event present
//   ev_ready       allocator can accept an event (registered)
//   ev_note        MIDI note number of the event
//   ev_on          1 = note-on, 0 = note-off
//   voice_note     packed per-voice note, voice v at [8v+7:8v]
//   voice_gate     per-voice gate
//   active_count   voices gated or in retrigger (registered)
//   steal_pulse    one-cycle pulse when a voice is stolen
//   drop_pulse     one-cycle pulse when a note-on is discarded
module voice_allocator #(
  parameter int unsigned NUM_VOICES    = 4,
  parameter int unsigned AGE_W         = 8,
  parameter int unsigned RETRIG_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ev_valid,
  output logic                              ev_ready,
  input  logic [7:0]                        ev_note,
  input  logic                              ev_on,
  output logic [8*NUM_VOICES-1:0]           voice_note,
  output logic [NUM_VOICES-1:0]             voice_gate,
  output logic [$clog2(NUM_VOICES+1)-1:0]   active_count,
  output logic                              steal_pulse,
  output logic                              drop_pulse
);

  localparam int unsigned VIdxW = $clog2(NUM_VOICES);
  localparam int unsigned CntW  = $clog2(NUM_VOICES + 1);
  localparam int unsigned RcW   = $clog2(RETRIG_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StSearch, StRetrig} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              ev_note_q, ev_note_d;
  logic                    ev_on_q, ev_on_d;
  logic [7:0]              note_q [NUM_VOICES];
  logic [7:0]              note_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]   gate_q, gate_d;
  logic [AGE_W-1:0]        age_q [NUM_VOICES];
  logic [AGE_W-1:0]        age_d [NUM_VOICES];
  logic [VIdxW-1:0]        tgt_q, tgt_d;
  logic [RcW-1:0]          rcnt_q, rcnt_d;
  logic [CntW-1:0]         active_q, active_d;
  logic                    steal_q, steal_d;
  logic                    drop_q, drop_d;
  logic                    ready_q, ready_d;

  // Search results over the current voice state.
  logic                    match_found, free_found;
  logic [VIdxW-1:0]        match_idx, free_idx;
  logic [VIdxW-1:0]        tgt;
  logic                    apply, retrig;

  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      if (!match_found && gate_q[i] && (note_q[i] == ev_note_q)) begin
        match_found = 1'b1;
        match_idx   = VIdxW'(i);
      end
      if (!free_found && !gate_q[i]) begin
        free_found = 1'b1;
        free_idx   = VIdxW'(i);
      end
    end
  end

`ifdef VOICE_ALLOC_STEAL_EN
  logic [VIdxW-1:0] steal_idx;
  logic [AGE_W-1:0] best_age;

  // Oldest voice; strict '>' keeps the lowest index on ties.
  always_comb begin
    steal_idx = '0;
    best_age  = age_q[0];
    for (int i = 1; i < int'(NUM_VOICES); i++) begin
      if (age_q[i] > best_age) begin
        best_age  = age_q[i];
        steal_idx = VIdxW'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    ev_note_d = ev_note_q;
    ev_on_d   = ev_on_q;
    note_d    = note_q;
    gate_d    = gate_q;
    age_d     = age_q;
    tgt_d     = tgt_q;
    rcnt_d    = rcnt_q;
    steal_d   = 1'b0;
    drop_d    = 1'b0;
    tgt       = '0;
    apply     = 1'b0;
    retrig    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ev_valid && ready_q) begin
          ev_note_d = ev_note;
          ev_on_d   = ev_on;
          state_d   = StSearch;
        end
      end

      StSearch: begin
        state_d = StIdle;
        if (ev_on_q) begin
          if (match_found) begin
            tgt          = match_idx;
            apply        = 1'b1;
            retrig       = 1'b1;
            gate_d[tgt]  = 1'b0;
          end else if (free_found) begin
            tgt          = free_idx;
            apply        = 1'b1;
            note_d[tgt]  = ev_note_q;
            gate_d[tgt]  = 1'b1;
          end else begin
`ifdef VOICE_ALLOC_STEAL_EN
            tgt          = steal_idx;
            apply        = 1'b1;
            retrig       = 1'b1;
            note_d[tgt]  = ev_note_q;
            gate_d[tgt]  = 1'b0;
            steal_d      = 1'b1;
`else
            drop_d       = 1'b1;
`endif
          end

          // Target restarts its age; other busy voices grow older (saturating).
          if (apply) begin
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
              if (VIdxW'(i) == tgt) begin
                age_d[i] = '0;
              end else if (gate_q[i] && (age_q[i] != '1)) begin
                age_d[i] = age_q[i] + AGE_W'(1);
              end
            end
          end

          if (retrig) begin
            state_d = StRetrig;
            tgt_d   = tgt;
            rcnt_d  = '0;
          end
        end else begin
          for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (gate_q[i] && (note_q[i] == ev_note_q)) begin
              gate_d[i] = 1'b0;
            end
          end
        end
      end

      StRetrig: begin
        if (rcnt_q == RcW'(RETRIG_CYCLES - 1)) begin
          gate_d[tgt_q] = 1'b1;
          state_d       = StIdle;
        end else begin
          rcnt_d = rcnt_q + RcW'(1);
        end
      end

      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);

    // Gated voices plus the retrigger target, which is busy but gated low.
    active_d = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      active_d = active_d + CntW'(gate_d[i]);
    end
    if (state_d == StRetrig) begin
      active_d = active_d + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ev_note_q <= '0;
      ev_on_q   <= 1'b0;
      note_q    <= '{default: '0};
      gate_q    <= '0;
      age_q     <= '{default: '0};
      tgt_q     <= '0;
      rcnt_q    <= '0;
      active_q  <= '0;
      steal_q   <= 1'b0;
      drop_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ev_note_q <= ev_note_d;
      ev_on_q   <= ev_on_d;
      note_q    <= note_d;
      gate_q    <= gate_d;
      age_q     <= age_d;
      tgt_q     <= tgt_d;
      rcnt_q    <= rcnt_d;
      active_q  <= active_d;
      steal_q   <= steal_d;
      drop_q    <= drop_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    voice_note = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      voice_note[8*i +: 8] = note_q[i];
    end
  end

  assign ev_ready     = ready_q;
  assign voice_gate   = gate_q;
  assign active_count = active_q;
  assign steal_pulse  = steal_q;
  assign drop_pulse   = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator (default parameters: 4 voices,
// RETRIG_CYCLES=4). Expectations follow VOICE_ALLOC_STEAL_EN when defined.
module tb_voice_allocator;

  logic        clk;
  logic        rst;
  logic        ev_valid;
  logic        ev_ready;
  logic [7:0]  ev_note;
  logic        ev_on;
  logic [31:0] voice_note;
  logic [3:0]  voice_gate;
  logic [2:0]  active_count;
  logic        steal_pulse;
  logic        drop_pulse;

  voice_allocator dut (
    .clk          (clk),
    .rst          (rst),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_note      (ev_note),
    .ev_on        (ev_on),
    .voice_note   (voice_note),
    .voice_gate   (voice_gate),
    .active_count (active_count),
    .steal_pulse  (steal_pulse),
    .drop_pulse   (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        on;
    logic [7:0]  note;
    logic [31:0] notes;
    logic [3:0]  gate;
    logic [2:0]  act;
    int          lat;     // edges from handshake until ev_ready returns
    int          steals;
    int          drops;
    int          lowv;    // voice whose gate-low cycles are counted
    int          lowcnt;
  } vec_t;

  vec_t vecs[13];
  vec_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic on, logic [7:0] note, logic [31:0] notes,
                              logic [3:0] gate, logic [2:0] act, int lat,
                              int st, int dr, int lowv, int lowcnt);
    vec_t v;
    v.on = on; v.note = note; v.notes = notes; v.gate = gate; v.act = act;
    v.lat = lat; v.steals = st; v.drops = dr; v.lowv = lowv; v.lowcnt = lowcnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Drive one event, push its expectation, observe completion, pop and compare.
  task automatic send(input vec_t v, input int idx);
    vec_t e;
    int lat, st, dr, low, k;
    exp_q.push_back(v);
    k = 0;
    @(negedge clk);
    while (!ev_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("ready_wait[%0d]", idx), 32'(ev_ready), 32'd1);
    ev_valid = 1'b1;
    ev_on    = v.on;
    ev_note  = v.note;
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    ev_on    = ~v.on;       // event must have been latched at handshake
    ev_note  = 8'hFF;
    lat = 0; st = 0; dr = 0; low = 0;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (steal_pulse) st++;
      if (drop_pulse) dr++;
      if (ev_ready) break;
      if (!voice_gate[v.lowv]) low++;
    end
    e = exp_q.pop_front();
    check($sformatf("latency[%0d]", idx), 32'(lat), 32'(e.lat));
    check($sformatf("notes[%0d]", idx), voice_note, e.notes);
    check($sformatf("gate[%0d]", idx), 32'(voice_gate), 32'(e.gate));
    check($sformatf("active[%0d]", idx), 32'(active_count), 32'(e.act));
    check($sformatf("steals[%0d]", idx), 32'(st), 32'(e.steals));
    check($sformatf("drops[%0d]", idx), 32'(dr), 32'(e.drops));
    check($sformatf("gate_low[%0d]", idx), 32'(low), 32'(e.lowcnt));
  endtask

  initial begin
    vecs[0]  = mk(1, 8'd72, 32'h0000_0048, 4'b0001, 3'd1, 1, 0, 0, 0, 0);
    vecs[1]  = mk(1, 8'd72, 32'h0000_0048, 4'b0001, 3'd1, 5, 0, 0, 0, 4);  // retrigger
    vecs[2]  = mk(0, 8'd99, 32'h0000_0048, 4'b0001, 3'd1, 1, 0, 0, 0, 0);  // no match
    vecs[3]  = mk(0, 8'd72, 32'h0000_0048, 4'b0000, 3'd0, 1, 0, 0, 0, 0);
    vecs[4]  = mk(1, 8'd60, 32'h0000_003C, 4'b0001, 3'd1, 1, 0, 0, 0, 0);
    vecs[5]  = mk(1, 8'd62, 32'h0000_3E3C, 4'b0011, 3'd2, 1, 0, 0, 1, 0);
    vecs[6]  = mk(1, 8'd64, 32'h0040_3E3C, 4'b0111, 3'd3, 1, 0, 0, 2, 0);
    vecs[7]  = mk(1, 8'd65, 32'h4140_3E3C, 4'b1111, 3'd4, 1, 0, 0, 3, 0);
`ifdef VOICE_ALLOC_STEAL_EN
    vecs[8]  = mk(1, 8'd67, 32'h4140_3E43, 4'b1111, 3'd4, 5, 1, 0, 0, 4);
    vecs[9]  = mk(0, 8'd62, 32'h4140_3E43, 4'b1101, 3'd3, 1, 0, 0, 1, 0);
    vecs[10] = mk(1, 8'd70, 32'h4140_4643, 4'b1111, 3'd4, 1, 0, 0, 1, 0);
    vecs[11] = mk(1, 8'd71, 32'h4147_4643, 4'b1111, 3'd4, 5, 1, 0, 2, 4);  // oldest is v2
    vecs[12] = mk(1, 8'd0,  32'h0047_4643, 4'b1111, 3'd4, 5, 1, 0, 3, 4);  // oldest is v3
`else
    vecs[8]  = mk(1, 8'd67, 32'h4140_3E3C, 4'b1111, 3'd4, 1, 0, 1, 0, 0);
    vecs[9]  = mk(0, 8'd62, 32'h4140_3E3C, 4'b1101, 3'd3, 1, 0, 0, 1, 0);
    vecs[10] = mk(1, 8'd70, 32'h4140_463C, 4'b1111, 3'd4, 1, 0, 0, 1, 0);
    vecs[11] = mk(1, 8'd71, 32'h4140_463C, 4'b1111, 3'd4, 1, 0, 1, 2, 0);
    vecs[12] = mk(1, 8'd0,  32'h4140_463C, 4'b1111, 3'd4, 1, 0, 1, 3, 0);
`endif

    rst = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ev_ready), 32'd0);
    check("rst_notes", voice_note, 32'd0);
    check("rst_gate", 32'(voice_gate), 32'd0);
    check("rst_active", 32'(active_count), 32'd0);
    check("rst_pulses", 32'({steal_pulse, drop_pulse}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(ev_ready), 32'd1);

    for (int i = 0; i < 13; i++) send(vecs[i], i);

    // Reset in the middle of a retrigger of voice 1 (note 70).
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 8'd70;
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    @(posedge clk);
    #1;
    check("retrig_gate1_low", 32'(voice_gate[1]), 32'd0);
    check("retrig_active", 32'(active_count), 32'd4);
    check("retrig_not_ready", 32'(ev_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_notes", voice_note, 32'd0);
    check("midrst_gate", 32'(voice_gate), 32'd0);
    check("midrst_active", 32'(active_count), 32'd0);
    check("midrst_ready", 32'(ev_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready_after", 32'(ev_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("midrst_gate_stays_low", 32'(voice_gate), 32'd0);
    check("midrst_ready_stays", 32'(ev_ready), 32'd1);
    send(mk(1, 8'd5, 32'h0000_0005, 4'b0001, 3'd1, 1, 0, 0, 0, 0), 13);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
